// File: rtl/pipeline_ctrl_if.sv
// Hazard/scheduling bus between the pipeline datapath and pipeline_ctrl.
// The datapath side (master) reports register usage and MD activity; the
// controller side (slave) returns the PC/IF_ID/ID_EX controls and MD status.
interface pipeline_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_br_rs;
    logic        id_br_rt;
    logic        id_is_md;
    logic        ex_we;
    logic        ex_is_load;
    logic [4:0]  ex_wreg;
    logic        mem_is_load;
    logic [4:0]  mem_wreg;
    logic        md_start;
    logic        md_is_div;
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_clr;
    logic        md_busy;
    logic        md_done;
    logic        md_overlap_err;
    logic [31:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_br_rs, id_br_rt, id_is_md,
               ex_we, ex_is_load, ex_wreg, mem_is_load, mem_wreg, md_start, md_is_div,
        input  pc_en, if_id_en, id_ex_clr, md_busy, md_done, md_overlap_err, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_br_rs, id_br_rt, id_is_md,
               ex_we, ex_is_load, ex_wreg, mem_is_load, mem_wreg, md_start, md_is_div,
        output pc_en, if_id_en, id_ex_clr, md_busy, md_done, md_overlap_err, stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard detection and multiply/divide scheduling for the five-stage pipeline.
// Stalls freeze PC and IF_ID and inject a bubble into ID_EX in the same cycle
// the hazard is seen; the MD unit is tracked with a down-counter.
module pipeline_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic           clk,
    input  logic           reset,
    pipeline_ctrl_if.slave bus
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_done_q, md_done_d;
    logic             md_err_q, md_err_d;
    logic [31:0]      stall_cycles_q, stall_cycles_d;

    logic rs_ex, rt_ex, rs_mem, rt_mem;
    logic load_use, br_ex, br_mem, md_haz, stall;
    logic md_busy;

    // Register $0 is hardwired to zero, so it never creates a dependency.
    function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
        return (dst != 5'd0) && (src == dst);
    endfunction

    assign md_busy = (cnt_q != '0);

    // Hazard terms and the resulting pipeline controls.
    always_comb begin
        rs_ex    = reg_hit(bus.id_rs, bus.ex_wreg);
        rt_ex    = reg_hit(bus.id_rt, bus.ex_wreg);
        rs_mem   = reg_hit(bus.id_rs, bus.mem_wreg);
        rt_mem   = reg_hit(bus.id_rt, bus.mem_wreg);
        load_use = bus.ex_is_load &
                   ((rs_ex & (bus.id_use_rs | bus.id_br_rs)) |
                    (rt_ex & (bus.id_use_rt | bus.id_br_rt)));
        br_ex    = bus.ex_we & ((rs_ex & bus.id_br_rs) | (rt_ex & bus.id_br_rt));
        br_mem   = bus.mem_is_load & ((rs_mem & bus.id_br_rs) | (rt_mem & bus.id_br_rt));
        md_haz   = bus.id_is_md & (md_busy | bus.md_start);
        stall    = load_use | br_ex | br_mem | md_haz;

        bus.pc_en     = 1'b1;
        bus.if_id_en  = 1'b1;
        bus.id_ex_clr = 1'b0;
        if (reset && stall) begin
            bus.pc_en     = 1'b0;
            bus.if_id_en  = 1'b0;
            bus.id_ex_clr = 1'b1;
        end
    end

    // Next-state for the MD countdown, done pulse, overlap flag and stall counter.
    always_comb begin
        cnt_d          = cnt_q;
        md_done_d      = 1'b0;
        md_err_d       = md_err_q;
        stall_cycles_d = stall_cycles_q;

        if (cnt_q != '0) begin
            cnt_d     = cnt_q - 1'b1;
            md_done_d = (cnt_q == CNT_W'(1));
            if (bus.md_start) begin
                md_err_d = 1'b1;
            end
        end else if (bus.md_start) begin
            cnt_d = bus.md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end

        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // State registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q          <= '0;
            md_done_q      <= 1'b0;
            md_err_q       <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            cnt_q          <= cnt_d;
            md_done_q      <= md_done_d;
            md_err_q       <= md_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.md_busy        = md_busy;
    assign bus.md_done        = md_done_q;
    assign bus.md_overlap_err = md_err_q;
    assign bus.stall_cycles   = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-indexed reference model.
module tb_pipeline_ctrl;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N),
        .CNT_W      (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: MD occupancy is the cycle window (start, busy_end].
    int          t;
    int          busy_end;
    bit          m_err;
    longint      m_stalls;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    function automatic bit dep(input logic [4:0] src, input logic [4:0] dst);
        return (dst != 0) && (src == dst);
    endfunction

    function automatic bit m_busy();
        return t <= busy_end;
    endfunction

    function automatic bit m_stall();
        bit lu, be, bm, mh;
        lu = bus.ex_is_load && ((dep(bus.id_rs, bus.ex_wreg) && (bus.id_use_rs || bus.id_br_rs)) ||
                                (dep(bus.id_rt, bus.ex_wreg) && (bus.id_use_rt || bus.id_br_rt)));
        be = bus.ex_we && ((dep(bus.id_rs, bus.ex_wreg) && bus.id_br_rs) ||
                           (dep(bus.id_rt, bus.ex_wreg) && bus.id_br_rt));
        bm = bus.mem_is_load && ((dep(bus.id_rs, bus.mem_wreg) && bus.id_br_rs) ||
                                 (dep(bus.id_rt, bus.mem_wreg) && bus.id_br_rt));
        mh = bus.id_is_md && (m_busy() || bus.md_start);
        return lu || be || bm || mh;
    endfunction

    task automatic model_reset();
        busy_end = -10;
        m_err    = 0;
        m_stalls = 0;
    endtask

    task automatic clear_inputs();
        bus.id_rs = 0;  bus.id_rt = 0;
        bus.id_use_rs = 0; bus.id_use_rt = 0;
        bus.id_br_rs = 0;  bus.id_br_rt = 0;
        bus.id_is_md = 0;
        bus.ex_we = 0; bus.ex_is_load = 0; bus.ex_wreg = 0;
        bus.mem_is_load = 0; bus.mem_wreg = 0;
        bus.md_start = 0; bus.md_is_div = 0;
    endtask

    // Let combinational outputs settle and compare everything against the model.
    task automatic check_cycle();
        bit s;
        #1;
        s = m_stall();
        check("pc_en",        bus.pc_en,          !s);
        check("if_id_en",     bus.if_id_en,       !s);
        check("id_ex_clr",    bus.id_ex_clr,      s);
        check("md_busy",      bus.md_busy,        m_busy());
        check("md_done",      bus.md_done,        (t == busy_end + 1));
        check("overlap_err",  bus.md_overlap_err, m_err);
        check("stall_cycles", bus.stall_cycles,   32'(m_stalls));
    endtask

    // Apply the model's update for the coming edge, then move to the next cycle.
    task automatic advance();
        if (m_stall() && m_stalls < 64'hFFFF_FFFF) m_stalls++;
        if (bus.md_start) begin
            if (m_busy()) m_err = 1;
            else busy_end = t + (bus.md_is_div ? DIV_N : MULT_N);
        end
        t++;
        @(negedge clk);
    endtask

    task automatic step();
        check_cycle();
        advance();
    endtask

    // Assert reset mid-cycle and check the forced/cleared values while it is low.
    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        check("rst_pc_en",     bus.pc_en,        1'b1);
        check("rst_if_id_en",  bus.if_id_en,     1'b1);
        check("rst_id_ex_clr", bus.id_ex_clr,    1'b0);
        check("rst_md_busy",   bus.md_busy,      1'b0);
        check("rst_md_done",   bus.md_done,      1'b0);
        check("rst_err",       bus.md_overlap_err, 1'b0);
        check("rst_stalls",    bus.stall_cycles, 32'd0);
        model_reset();
        t++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        t     = 0;
        model_reset();
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        bus.id_is_md = 1; bus.md_start = 1;  // hazard inputs must be masked by reset
        pulse_reset();
        clear_inputs();

        // Load-use: single stall cycle.
        bus.ex_is_load = 1; bus.ex_wreg = 8; bus.id_rs = 8; bus.id_use_rs = 1;
        check_cycle();
        check("lu_clr", bus.id_ex_clr, 1'b1);
        advance();
        clear_inputs();
        check_cycle();
        check("lu_count", bus.stall_cycles, 32'd1);
        advance();

        // Branch on ALU producer: 1 stall.
        bus.ex_we = 1; bus.ex_wreg = 9; bus.id_rt = 9; bus.id_br_rt = 1;
        step();
        // Branch on load producer: EX then MEM, 2 stalls.
        bus.ex_is_load = 1;
        step();
        bus.ex_we = 0; bus.ex_is_load = 0; bus.ex_wreg = 0;
        bus.mem_is_load = 1; bus.mem_wreg = 9;
        check_cycle();
        check("brmem_clr", bus.id_ex_clr, 1'b1);
        advance();
        clear_inputs();
        check_cycle();
        check("br_count", bus.stall_cycles, 32'd4);
        advance();

        // $0 never stalls.
        bus.ex_is_load = 1; bus.ex_wreg = 0; bus.id_rs = 0; bus.id_use_rs = 1;
        check_cycle();
        check("zero_reg", bus.pc_en, 1'b1);
        advance();
        clear_inputs();

        // Mult then waiting mflo.
        bus.md_start = 1; bus.id_is_md = 1;
        for (int k = 0; k <= 6; k++) begin
            check_cycle();
            if (k == 3) check("mult_busy", bus.md_busy, 1'b1);
            if (k == 6) begin
                check("mult_done",    bus.md_done,   1'b1);
                check("mult_release", bus.id_ex_clr, 1'b0);
            end
            advance();
            bus.md_start = 0;
        end
        clear_inputs();

        // Div with overlapping start three cycles later.
        for (int k = 0; k <= 12; k++) begin
            bus.md_start  = (k == 0 || k == 3);
            bus.md_is_div = bus.md_start;
            check_cycle();
            if (k == 10) check("div_busy_end", bus.md_busy, 1'b1);
            if (k == 11) begin
                check("div_done", bus.md_done, 1'b1);
                check("div_err",  bus.md_overlap_err, 1'b1);
            end
            advance();
        end
        clear_inputs();

        // Reset in the middle of a div aborts it with no done pulse.
        for (int k = 0; k < 4; k++) begin
            bus.md_start = (k == 0); bus.md_is_div = 1;
            step();
        end
        clear_inputs();
        bus.id_is_md = 1;
        check_cycle();
        pulse_reset();
        clear_inputs();
        for (int k = 0; k < 12; k++) step();

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            bus.id_rs       = 5'($urandom_range(0, 3));
            bus.id_rt       = 5'($urandom_range(0, 3));
            bus.id_use_rs   = 1'($urandom_range(0, 1));
            bus.id_use_rt   = 1'($urandom_range(0, 1));
            bus.id_br_rs    = ($urandom_range(0, 3) == 0);
            bus.id_br_rt    = ($urandom_range(0, 3) == 0);
            bus.id_is_md    = ($urandom_range(0, 3) == 0);
            bus.ex_we       = 1'($urandom_range(0, 1));
            bus.ex_is_load  = ($urandom_range(0, 2) == 0);
            bus.ex_wreg     = 5'($urandom_range(0, 3));
            bus.mem_is_load = ($urandom_range(0, 2) == 0);
            bus.mem_wreg    = 5'($urandom_range(0, 3));
            bus.md_start    = ($urandom_range(0, 7) == 0);
            bus.md_is_div   = 1'($urandom_range(0, 1));
            check_cycle();
            if ($urandom_range(0, 299) == 0) pulse_reset();
            else advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and multi-cycle scheduler for the five-stage MIPS pipeline. It watches register usage in ID, EX and MEM and the busy state of the multiply/divide unit (HI/LO). It drives the enable and clear controls of the PC, IF_ID and ID_EX registers. EX_MEM and MEM_WB always advance; stalls are resolved by inserting bubbles at ID_EX, which then drain through EX_MEM and MEM_WB as `nop`.

## Interface
- MULT_CYCLES, 5, EX-occupancy cycles of mult/multu
- DIV_CYCLES, 10, EX-occupancy cycles of div/divu
- CNT_W, 4, width of the MD countdown; must hold max(MULT_CYCLES, DIV_CYCLES)
- clk  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- id_rs, id_rt  input  5 each  source registers of the instruction in ID
- id_use_rs, id_use_rt  input  1 each  operand is read in EX (forwardable)
- id_br_rs, id_br_rt  input  1 each  operand is read in ID by a branch/jr compare
- id_is_md  input  1  ID instruction uses the MD unit (mult/div/mfhi/mflo/mthi/mtlo)
- ex_we, ex_is_load  input  1 each  EX instruction writes GPR / is a load
- ex_wreg  input  5  EX destination register
- mem_is_load  input  1  MEM instruction is a load
- mem_wreg  input  5  MEM destination register
- md_start  input  1  EX holds mult/multu/div/divu this cycle (one-cycle pulse)
- md_is_div  input  1  qualifies md_start: 1 = div/divu
- pc_en  output  1  PC register load enable
- if_id_en  output  1  IF_ID load enable
- id_ex_clr  output  1  ID_EX loads a bubble (instr 0, code `nop`)
- md_busy  output  1  MD unit occupied
- md_done  output  1  one-cycle pulse when HI/LO become valid
- md_overlap_err  output  1  sticky: md_start seen while md_busy
- stall_cycles  output  32  saturating count of stalled cycles

## Operation
- Register $0 never causes a hazard; every compare below also requires the register to be nonzero.
- load_use = ex_is_load and ex_wreg matches an ID source with id_use_* or id_br_* set.
- br_ex = ex_we and ex_wreg matches a source with id_br_* set.
- br_mem = mem_is_load and mem_wreg matches a source with id_br_* set.
- md_haz = id_is_md and (md_busy or md_start).
- stall = load_use | br_ex | br_mem | md_haz.
- When stall is set, pc_en = 0, if_id_en = 0 and id_ex_clr = 1. Otherwise pc_en = 1, if_id_en = 1 and id_ex_clr = 0. These outputs are combinational from the current inputs and state.
- MD countdown `cnt`, CNT_W bits:
  - On md_start with cnt == 0, cnt loads DIV_CYCLES if md_is_div is set, else MULT_CYCLES.
  - When cnt > 0, cnt decrements by 1 each cycle.
- md_busy = (cnt != 0), registered state.
- md_done is registered and goes high for exactly one cycle, the cycle after cnt transitions 1 → 0.
- md_start while cnt != 0 is ignored: the count is not reloaded and md_overlap_err sets and holds until reset.
- stall_cycles increments by 1 on every clock where stall = 1. It saturates at 32'hFFFF_FFFF and does not wrap.

## Timing
- While reset = 0, all state clears asynchronously: cnt = 0, md_busy = 0, md_done = 0, md_overlap_err = 0, stall_cycles = 0.
- While reset = 0, the outputs are forced to pc_en = 1, if_id_en = 1, id_ex_clr = 0 regardless of the inputs.
- First rising edge after reset deasserts: normal operation.
- Stall response is zero-latency, in the same cycle as the hazard.
- Load-use: exactly 1 stall cycle.
- br_ex followed by br_mem on a load: 2 stall cycles; br_ex on an ALU producer: 1 stall cycle.
- Mult timeline, md_start at edge-cycle T:
  - md_busy is high in cycles T+1 .. T+MULT_CYCLES.
  - md_done is high in cycle T+MULT_CYCLES+1.
  - A waiting mfhi/mflo is released (stall = 0) in cycle T+MULT_CYCLES+1.
- Div follows the same timeline with DIV_CYCLES in place of MULT_CYCLES.
- Reset asserted mid-count aborts the operation; no md_done is produced.
- Hazards in the same cycle are OR-ed; the stall length is the longest of them, never their sum.

## Test plan
- **Load-use:** ex_is_load = 1, ex_wreg = 8; id_rs = 8 with id_use_rs = 1 → one cycle of pc_en = 0, if_id_en = 0, id_ex_clr = 1; stall_cycles = 1.
- **Branch hazards:**
  - ALU producer: ex_we = 1, ex_wreg = 9; id_rt = 9 with id_br_rt = 1 → 1 stall cycle.
  - Load producer: same case with ex_is_load = 1 → 2 stall cycles (EX then MEM); stall_cycles = 2.
- **$0 filter:** ex_is_load = 1, ex_wreg = 0, id_rs = 0 with id_use_rs = 1 → no stall.
- **Mult then mflo:** md_start with md_is_div = 0 at cycle 0, id_is_md = 1 held → stall in cycles 0–5; md_done = 1 in cycle 6; stall = 0 in cycle 6; md_busy = 1 in cycles 1–5.
- **Div overlap:** md_start with md_is_div = 1, then md_start again 3 cycles later → cnt is not reloaded, md_overlap_err = 1 sticky, md_done fires in cycle 11.
- **Reset mid-div:** reset = 0 at cycle 4 of a div → md_busy = 0 immediately, no md_done pulse, stall_cycles = 0, pc_en = 1 during reset.
